// File: rtl/inst_sram64_bridge.sv
// Fetch-side 64-bit instruction port responder: splits each 8-byte line request
// into two 32-bit bus beats, with a single-entry line buffer for repeat hits.
module inst_sram64_bridge #(
  parameter bit LINE_BUF_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_sram_en,
  input  logic [31:0] inst_sram_addr,
  output logic [63:0] inst_sram_rdata,
  output logic        inst_sram_data_ok,
  input  logic        flush,
  input  logic        buf_inv,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_addr_ok,
  input  logic        ibus_data_ok,
  input  logic [31:0] ibus_rdata
);

  typedef enum logic [2:0] {IDLE, REQ0, REQ1, WAIT, DRAIN, RESP} state_t;

  state_t      state, state_nxt;
  logic [28:0] line_tag;
  logic [1:0]  outst, outst_nxt;
  logic [1:0]  rcv;
  logic [31:0] beat0;
  logic        buf_vld;
  logic [28:0] buf_tag;
  logic [63:0] buf_data;
  logic [63:0] rdata_q;

  logic accept, hit, addr_acc, dok_acc, last_beat, fill_done;
  logic unused_addr_lsb;

  assign unused_addr_lsb = ^inst_sram_addr[2:0];

  assign accept    = (state == IDLE) && inst_sram_en && !flush;
  assign hit       = LINE_BUF_EN && buf_vld && (buf_tag == inst_sram_addr[31:3]);
  assign addr_acc  = ibus_req && ibus_addr_ok;
  assign dok_acc   = ibus_data_ok && (state == REQ1 || state == WAIT || state == DRAIN);
  // Beat 1 can only come back after its own address was issued, i.e. in WAIT.
  assign last_beat = (state == WAIT) && dok_acc && (rcv == 2'd1);
  assign fill_done = last_beat && !flush;

  assign ibus_req          = (state == REQ0) || (state == REQ1);
  assign inst_sram_data_ok = (state == RESP);
  assign inst_sram_rdata   = rdata_q;

  always_comb begin
    ibus_addr = '0;
    if (state == REQ0) ibus_addr = {line_tag, 3'b000};
    else if (state == REQ1) ibus_addr = {line_tag, 3'b100};
  end

  always_comb begin
    outst_nxt = outst;
    case ({addr_acc, dok_acc})
      2'b10:   outst_nxt = outst + 2'd1;
      2'b01:   outst_nxt = outst - 2'd1;
      default: outst_nxt = outst;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = hit ? RESP : REQ0;
      REQ0: begin
        // An address accepted in the flush cycle is still owed a data beat.
        if (flush)         state_nxt = addr_acc ? DRAIN : IDLE;
        else if (addr_acc) state_nxt = REQ1;
      end
      REQ1: begin
        if (flush)         state_nxt = (outst_nxt == 2'd0) ? IDLE : DRAIN;
        else if (addr_acc) state_nxt = WAIT;
      end
      WAIT: begin
        if (flush)          state_nxt = (outst_nxt == 2'd0) ? IDLE : DRAIN;
        else if (last_beat) state_nxt = RESP;
      end
      DRAIN: if (outst_nxt == 2'd0) state_nxt = IDLE;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      outst    <= '0;
      rcv      <= '0;
      line_tag <= '0;
      beat0    <= '0;
      buf_vld  <= 1'b0;
      buf_tag  <= '0;
      buf_data <= '0;
      rdata_q  <= '0;
    end else begin
      state <= state_nxt;
      outst <= outst_nxt;
      if (accept) begin
        line_tag <= inst_sram_addr[31:3];
        rcv      <= '0;
      end else if (dok_acc && state != DRAIN) begin
        rcv <= rcv + 2'd1;
        if (rcv == 2'd0) beat0 <= ibus_rdata;
      end
      if (accept && hit) rdata_q <= buf_data;
      if (fill_done) begin
        rdata_q  <= {beat0, ibus_rdata};
        buf_tag  <= line_tag;
        buf_data <= {beat0, ibus_rdata};
      end
      if (buf_inv)        buf_vld <= 1'b0;
      else if (fill_done) buf_vld <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_sram64_bridge.sv
// Cycle-by-cycle directed vectors for inst_sram64_bridge; the bus side is
// scripted per cycle in the same table as the expected outputs.
module tb_inst_sram64_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [63:0] inst_sram_rdata;
  logic        inst_sram_data_ok;
  logic        flush;
  logic        buf_inv;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_addr_ok;
  logic        ibus_data_ok;
  logic [31:0] ibus_rdata;

  inst_sram64_bridge #(.LINE_BUF_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr),
    .inst_sram_rdata(inst_sram_rdata), .inst_sram_data_ok(inst_sram_data_ok),
    .flush(flush), .buf_inv(buf_inv),
    .ibus_req(ibus_req), .ibus_addr(ibus_addr),
    .ibus_addr_ok(ibus_addr_ok), .ibus_data_ok(ibus_data_ok), .ibus_rdata(ibus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, en;
    logic [31:0] addr;
    logic        flush, inv, aok, dok;
    logic [31:0] bd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_dok, chk_rd;
    logic [63:0] e_rd;
  } vec_t;

  localparam logic [31:0] B = 32'hBFC00000;

  vec_t tbl[$];
  int   tests = 0;
  int   fails = 0;

  task automatic v(input logic r, input logic en, input logic [31:0] a, input logic fl,
                   input logic inv, input logic aok, input logic dok, input logic [31:0] bd,
                   input logic ereq, input logic [31:0] eaddr, input logic edok,
                   input logic chk, input logic [63:0] erd);
    vec_t t;
    t.rst = r; t.en = en; t.addr = a; t.flush = fl; t.inv = inv; t.aok = aok; t.dok = dok;
    t.bd = bd; t.e_req = ereq; t.e_addr = eaddr; t.e_dok = edok; t.chk_rd = chk; t.e_rd = erd;
    tbl.push_back(t);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic en, input logic [31:0] a, input logic fl,
                       input logic inv, input logic aok, input logic dok, input logic [31:0] bd);
    rst = r; inst_sram_en = en; inst_sram_addr = a; flush = fl; buf_inv = inv;
    ibus_addr_ok = aok; ibus_data_ok = dok; ibus_rdata = bd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic got;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    next_cycle();

    //  rst en addr     fl inv aok dok bus data      req addr     dok chk rdata
    v(0, 0, 32'h0,    0, 0, 0, 0, 32'h0,        0, 32'h0,    0, 1, 64'h0);
    // miss on B
    v(0, 1, B,        0, 0, 0, 0, 32'h0,        0, 32'h0,    0, 1, 64'h0);
    v(0, 0, 32'h0,    0, 0, 1, 0, 32'h0,        1, B,        0, 0, 64'h0);
    v(0, 0, 32'h0,    0, 0, 1, 1, 32'h11111111, 1, B+4,      0, 0, 64'h0);
    v(0, 0, 32'h0,    0, 0, 0, 1, 32'h22222222, 0, 32'h0,    0, 1, 64'h0);
    v(0, 0, 32'h0,    0, 0, 0, 0, 32'h0,        0, 32'h0,    1, 1, 64'h11111111_22222222);
    // hit on B+4, latency 1
    v(0, 1, B+4,      0, 0, 0, 0, 32'h0,        0, 32'h0,    0, 1, 64'h11111111_22222222);
    v(0, 0, 32'h0,    0, 0, 0, 0, 32'h0,        0, 32'h0,    1, 1, 64'h11111111_22222222);
    // flush in WAIT with one beat outstanding
    v(0, 1, B+32'h18, 0, 0, 0, 0, 32'h0,        0, 32'h0,    0, 0, 64'h0);
    v(0, 0, 32'h0,    0, 0, 1, 0, 32'h0,        1, B+32'h18, 0, 0, 64'h0);
    v(0, 0, 32'h0,    0, 0, 1, 1, 32'hAAAAAAAA, 1, B+32'h1C, 0, 0, 64'h0);
    v(0, 0, 32'h0,    1, 0, 0, 0, 32'h0,        0, 32'h0,    0, 0, 64'h0);
    v(0, 0, 32'h0,    0, 0, 0, 1, 32'hBBBBBBBB, 0, 32'h0,    0, 1, 64'h11111111_22222222);
    // B still hits after the flush
    v(0, 1, B,        0, 0, 0, 0, 32'h0,        0, 32'h0,    0, 1, 64'h11111111_22222222);
    v(0, 0, 32'h0,    0, 0, 0, 0, 32'h0,        0, 32'h0,    1, 1, 64'h11111111_22222222);
    // miss on B+0x10
    v(0, 1, B+32'h10, 0, 0, 0, 0, 32'h0,        0, 32'h0,    0, 0, 64'h0);
    v(0, 0, 32'h0,    0, 0, 1, 0, 32'h0,        1, B+32'h10, 0, 0, 64'h0);
    v(0, 0, 32'h0,    0, 0, 1, 1, 32'h55555555, 1, B+32'h14, 0, 0, 64'h0);
    v(0, 0, 32'h0,    0, 0, 0, 1, 32'h66666666, 0, 32'h0,    0, 0, 64'h0);
    v(0, 0, 32'h0,    0, 0, 0, 0, 32'h0,        0, 32'h0,    1, 1, 64'h55555555_66666666);
    // address stall for 5 cycles in REQ0
    v(0, 1, B+8,      0, 0, 0, 0, 32'h0,        0, 32'h0,    0, 0, 64'h0);
    for (int i = 0; i < 5; i++)
      v(0, 0, 32'h0,  0, 0, 0, 0, 32'h0,        1, B+8,      0, 0, 64'h0);
    v(0, 0, 32'h0,    0, 0, 1, 0, 32'h0,        1, B+8,      0, 0, 64'h0);
    v(0, 0, 32'h0,    0, 0, 1, 1, 32'h33333333, 1, B+32'hC,  0, 0, 64'h0);
    v(0, 0, 32'h0,    0, 0, 0, 1, 32'h44444444, 0, 32'h0,    0, 0, 64'h0);
    v(0, 0, 32'h0,    0, 0, 0, 0, 32'h0,        0, 32'h0,    1, 1, 64'h33333333_44444444);
    v(0, 1, B+8,      0, 0, 0, 0, 32'h0,        0, 32'h0,    0, 0, 64'h0);
    v(0, 0, 32'h0,    0, 0, 0, 0, 32'h0,        0, 32'h0,    1, 1, 64'h33333333_44444444);
    // buf_inv, then the buffered line misses; buf_inv again on the fill cycle
    v(0, 0, 32'h0,    0, 1, 0, 0, 32'h0,        0, 32'h0,    0, 0, 64'h0);
    v(0, 1, B+8,      0, 0, 0, 0, 32'h0,        0, 32'h0,    0, 0, 64'h0);
    v(0, 0, 32'h0,    0, 0, 1, 0, 32'h0,        1, B+8,      0, 0, 64'h0);
    v(0, 0, 32'h0,    0, 0, 1, 1, 32'h77777777, 1, B+32'hC,  0, 0, 64'h0);
    v(0, 0, 32'h0,    0, 1, 0, 1, 32'h88888888, 0, 32'h0,    0, 0, 64'h0);
    v(0, 0, 32'h0,    0, 0, 0, 0, 32'h0,        0, 32'h0,    1, 1, 64'h77777777_88888888);
    // buffer must still be invalid: another miss
    v(0, 1, B+8,      0, 0, 0, 0, 32'h0,        0, 32'h0,    0, 0, 64'h0);
    v(0, 0, 32'h0,    0, 0, 1, 0, 32'h0,        1, B+8,      0, 0, 64'h0);
    v(0, 0, 32'h0,    0, 0, 1, 1, 32'h12345678, 1, B+32'hC,  0, 0, 64'h0);
    v(0, 0, 32'h0,    0, 0, 0, 1, 32'h9ABCDEF0, 0, 32'h0,    0, 0, 64'h0);
    v(0, 0, 32'h0,    0, 0, 0, 0, 32'h0,        0, 32'h0,    1, 1, 64'h12345678_9ABCDEF0);
    v(0, 1, B+8,      0, 0, 0, 0, 32'h0,        0, 32'h0,    0, 0, 64'h0);
    v(0, 0, 32'h0,    0, 0, 0, 0, 32'h0,        0, 32'h0,    1, 1, 64'h12345678_9ABCDEF0);
    // reset mid-WAIT, then the previously buffered line misses
    v(0, 1, B+32'h20, 0, 0, 0, 0, 32'h0,        0, 32'h0,    0, 0, 64'h0);
    v(0, 0, 32'h0,    0, 0, 1, 0, 32'h0,        1, B+32'h20, 0, 0, 64'h0);
    v(0, 0, 32'h0,    0, 0, 1, 1, 32'hCCCCCCCC, 1, B+32'h24, 0, 0, 64'h0);
    v(1, 0, 32'h0,    0, 0, 0, 0, 32'h0,        0, 32'h0,    0, 1, 64'h12345678_9ABCDEF0);
    v(0, 1, B+8,      0, 0, 0, 0, 32'h0,        0, 32'h0,    0, 1, 64'h0);
    v(0, 0, 32'h0,    0, 0, 1, 0, 32'h0,        1, B+8,      0, 1, 64'h0);
    v(0, 0, 32'h0,    0, 0, 1, 1, 32'hDEADBEEF, 1, B+32'hC,  0, 0, 64'h0);
    v(0, 0, 32'h0,    0, 0, 0, 1, 32'h0BADF00D, 0, 32'h0,    0, 0, 64'h0);
    v(0, 0, 32'h0,    0, 0, 0, 0, 32'h0,        0, 32'h0,    1, 1, 64'hDEADBEEF_0BADF00D);
    v(0, 0, 32'h0,    0, 0, 0, 0, 32'h0,        0, 32'h0,    0, 1, 64'hDEADBEEF_0BADF00D);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].addr, tbl[i].flush, tbl[i].inv,
            tbl[i].aok, tbl[i].dok, tbl[i].bd);
      @(negedge clk);
      check($sformatf("v%0d ibus_req", i), 64'(ibus_req), 64'(tbl[i].e_req));
      check($sformatf("v%0d data_ok", i), 64'(inst_sram_data_ok), 64'(tbl[i].e_dok));
      if (tbl[i].e_req) check($sformatf("v%0d ibus_addr", i), 64'(ibus_addr), 64'(tbl[i].e_addr));
      if (tbl[i].chk_rd) check($sformatf("v%0d rdata", i), inst_sram_rdata, tbl[i].e_rd);
      next_cycle();
    end

    // flush in IDLE beats en even for a line that would hit
    drive(1'b0, 1'b1, B+8, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("idle_flush data_ok", 64'(inst_sram_data_ok), 64'h0);
    check("idle_flush ibus_req", 64'(ibus_req), 64'h0);
    next_cycle();

    // flush in REQ0 before addr_ok drops the request
    drive(1'b0, 1'b1, B+32'h30, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("req0_flush req before", 64'(ibus_req), 64'h1);
    check("req0_flush addr before", 64'(ibus_addr), 64'(B+32'h30));
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("req0_flush req after", 64'(ibus_req), 64'h0);
    check("req0_flush data_ok", 64'(inst_sram_data_ok), 64'h0);
    next_cycle();

    // buffered line still answered, within a bounded wait
    drive(1'b0, 1'b1, B+8, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    got = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin
      @(negedge clk);
      if (inst_sram_data_ok) got = 1'b1;
      else next_cycle();
    end
    check("final hit data_ok seen", 64'(got), 64'h1);
    check("final hit rdata", inst_sram_rdata, 64'hDEADBEEF_0BADF00D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
